stage3_mul_pipe: RTL and testbench

STAGE3_MUL_PIPE -- requirements
Module: stage3_mul_pipe

---
 rtl/sbox_pkg.sv | 42 ++++
 rtl/dom_gf16_mul.sv | 45 ++++
 rtl/stage3_mul_pipe.sv | 128 ++++++++++++
 tb/tb_stage3_mul_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared GF(2^4) arithmetic for the masked S-box multiplier stage.
// GF(16) is built as a tower GF((2^2)^2):
//   GF(4)  = GF(2)[w]/(w^2 + w + 1), element {x1,x0} = x1*w + x0
//   GF(16) = GF(4)[z]/(z^2 + z + w), element {h,l}  = h*z + l
// Also holds the nibble width and the lane bit-offset helpers.
package sbox_pkg;

  localparam int unsigned Gf16W = 4;

  // GF(4) product, reduced with w^2 = w + 1.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  // Multiply by the tower constant N = w.
  function automatic logic [1:0] gf4_mul_n(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // GF(16) product in the tower basis, reduced with z^2 = z + N.
  function automatic logic [Gf16W-1:0] gf16_mul(input logic [Gf16W-1:0] a,
                                                input logic [Gf16W-1:0] b);
    logic [1:0] hh, hi, lo;
    hh = gf4_mul(a[3:2], b[3:2]);
    hi = hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]);
    lo = gf4_mul_n(hh) ^ gf4_mul(a[1:0], b[1:0]);
    return {hi, lo};
  endfunction

  // Bit offset of lane k in a 4-bit-per-lane operand bus.
  function automatic int unsigned nib_base(input int unsigned k);
    return k * Gf16W;
  endfunction

  // Bit offset of lane k in an 8-bit-per-lane rnd/output bus.
  function automatic int unsigned byte_base(input int unsigned k);
    return k * 2 * Gf16W;
  endfunction

endpackage

// File: rtl/dom_gf16_mul.sv
// One 2-share DOM-indep GF(16) multiplier (a*b) with registered terms.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears all term registers)
//   en         : load enable for all four term registers
//   a0, a1     : shares of operand a
//   b0, b1     : shares of operand b
//   r          : fresh mask shared by the two cross-domain terms
//   q0, q1     : output shares, compressed from registered terms only
module dom_gf16_mul
  import sbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [Gf16W-1:0] a0,
  input  logic [Gf16W-1:0] a1,
  input  logic [Gf16W-1:0] b0,
  input  logic [Gf16W-1:0] b1,
  input  logic [Gf16W-1:0] r,
  output logic [Gf16W-1:0] q0,
  output logic [Gf16W-1:0] q1
);

  logic [Gf16W-1:0] t00_q, t01_q, t10_q, t11_q;

  // Cross-domain terms are masked with r before the register so no unmasked
  // mix of both shares ever feeds the compression XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t00_q <= '0;
      t01_q <= '0;
      t10_q <= '0;
      t11_q <= '0;
    end else if (en) begin
      t00_q <= gf16_mul(a0, b0);
      t01_q <= gf16_mul(a0, b1) ^ r;
      t10_q <= gf16_mul(a1, b0) ^ r;
      t11_q <= gf16_mul(a1, b1);
    end
  end

  assign q0 = t00_q ^ t01_q;
  assign q1 = t11_q ^ t10_q;

endmodule

// File: rtl/stage3_mul_pipe.sv
// Masked S-box stage 3: per lane, multiplies the high and low nibble operands
// by a common multiplier using 2-share DOM-indep multipliers.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   inh0/inh1, inl0/inl1 : shares of high / low nibble operands (4 bits per lane)
//   in0/in1              : shares of the common multiplier (4 bits per lane)
//   in_valid / in_ready  : operand handshake
//   rnd / rnd_valid      : fresh randomness (8 bits per lane); rnd_ack pulses on use
//   out0/out1            : output shares, lane byte = {high product, low product}
//   out_valid/out_ready  : output handshake
// OUT_REG=0 gives 1-cycle latency, OUT_REG=1 adds an output register (latency 2).
module stage3_mul_pipe
  import sbox_pkg::*;
#(
  parameter int unsigned LANES   = 1,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*4-1:0]     inh0,
  input  logic [LANES*4-1:0]     inh1,
  input  logic [LANES*4-1:0]     inl0,
  input  logic [LANES*4-1:0]     inl1,
  input  logic [LANES*4-1:0]     in0,
  input  logic [LANES*4-1:0]     in1,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*8-1:0]     rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ack,
  output logic [LANES*8-1:0]     out0,
  output logic [LANES*8-1:0]     out1,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned BusW = LANES * 2 * Gf16W;

  logic            fire;
  logic            v1_q;
  logic [BusW-1:0] comp0, comp1;

  assign fire    = in_valid & rnd_valid & in_ready;
  assign rnd_ack = fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned Nb = nib_base(k);
    localparam int unsigned Bb = byte_base(k);

    dom_gf16_mul u_hi (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (fire),
      .a0    (inh0[Nb +: Gf16W]),
      .a1    (inh1[Nb +: Gf16W]),
      .b0    (in0[Nb +: Gf16W]),
      .b1    (in1[Nb +: Gf16W]),
      .r     (rnd[Bb +: Gf16W]),
      .q0    (comp0[Bb + Gf16W +: Gf16W]),
      .q1    (comp1[Bb + Gf16W +: Gf16W])
    );

    dom_gf16_mul u_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (fire),
      .a0    (inl0[Nb +: Gf16W]),
      .a1    (inl1[Nb +: Gf16W]),
      .b0    (in0[Nb +: Gf16W]),
      .b1    (in1[Nb +: Gf16W]),
      .r     (rnd[Bb + Gf16W +: Gf16W]),
      .q0    (comp0[Bb +: Gf16W]),
      .q1    (comp1[Bb +: Gf16W])
    );
  end

  if (OUT_REG == 0) begin : g_direct
    // Term registers are the only stage; compressed shares drive the outputs.
    assign in_ready  = !v1_q | out_ready;
    assign out_valid = v1_q;
    assign out0      = comp0;
    assign out1      = comp1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q <= 1'b0;
      end else if (fire) begin
        v1_q <= 1'b1;
      end else if (out_ready) begin
        v1_q <= 1'b0;
      end
    end
  end else begin : g_outreg
    logic            v2_q;
    logic            adv2;
    logic [BusW-1:0] o0_q, o1_q;

    // Output stage can take a new value when empty or being drained.
    assign adv2      = !v2_q | out_ready;
    assign in_ready  = !v1_q | adv2;
    assign out_valid = v2_q;
    assign out0      = o0_q;
    assign out1      = o1_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
        o0_q <= '0;
        o1_q <= '0;
      end else begin
        if (fire) begin
          v1_q <= 1'b1;
        end else if (adv2) begin
          v1_q <= 1'b0;
        end
        if (adv2) begin
          v2_q <= v1_q;
        end
        if (adv2 && v1_q) begin
          o0_q <= comp0;
          o1_q <= comp1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage3_mul_pipe.sv
// Bench for stage3_mul_pipe: two LANES=4 instances (OUT_REG=0 and 1) checked
// against a transaction-level model (queue of expected share words).
module tb_stage3_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic [15:0] inh0[2], inh1[2], inl0[2], inl1[2], in0[2], in1[2];
  logic [31:0] rnd[2], out0[2], out1[2];
  logic        in_valid[2], rnd_valid[2], out_ready[2];
  logic        in_ready[2], rnd_ack[2], out_valid[2];

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;
  int          cyc   = 0;
  logic [31:0] q0[$], q1[$];
  int          fq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stage3_mul_pipe #(.LANES(4), .OUT_REG(g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inh0      (inh0[g]),
      .inh1      (inh1[g]),
      .inl0      (inl0[g]),
      .inl1      (inl1[g]),
      .in0       (in0[g]),
      .in1       (in1[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .rnd       (rnd[g]),
      .rnd_valid (rnd_valid[g]),
      .rnd_ack   (rnd_ack[g]),
      .out0      (out0[g]),
      .out1      (out1[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // GF(4) = GF(2)[w]/(w^2+w+1): carry-less multiply then reduce.
  function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] p;
    p = 3'b000;
    for (int i = 0; i < 2; i++) if (b[i]) p = p ^ ({1'b0, a} << i);
    if (p[2]) p = p ^ 3'b111;
    return p[1:0];
  endfunction

  // GF(16) = GF(4)[z]/(z^2+z+w): schoolbook product then reduce the z^2 term.
  function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] c2, c1, c0;
    c2 = m4(a[3:2], b[3:2]);
    c1 = m4(a[3:2], b[1:0]) ^ m4(a[1:0], b[3:2]);
    c0 = m4(a[1:0], b[1:0]);
    return {c1 ^ c2, c0 ^ m4(c2, 2'b10)};
  endfunction

  // Expected output share s: share_s = a_s * (b0^b1) ^ r per product.
  function automatic logic [31:0] model_share(input int d, input int s);
    logic [31:0] w;
    logic [3:0]  b, ah, al;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b  = in0[d][4*k +: 4] ^ in1[d][4*k +: 4];
      ah = (s == 0) ? inh0[d][4*k +: 4] : inh1[d][4*k +: 4];
      al = (s == 0) ? inl0[d][4*k +: 4] : inl1[d][4*k +: 4];
      w[8*k+4 +: 4] = m16(ah, b) ^ rnd[d][8*k +: 4];
      w[8*k +: 4]   = m16(al, b) ^ rnd[d][8*k+4 +: 4];
    end
    return w;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      inh0[d] = '0; inh1[d] = '0; inl0[d] = '0; inl1[d] = '0;
      in0[d] = '0; in1[d] = '0; rnd[d] = '0;
      in_valid[d] = 1'b0; rnd_valid[d] = 1'b0; out_ready[d] = 1'b1;
    end
  endtask

  task automatic rand_ops(input int d);
    inh0[d] = 16'($urandom); inh1[d] = 16'($urandom);
    inl0[d] = 16'($urandom); inl1[d] = 16'($urandom);
    in0[d]  = 16'($urandom); in1[d]  = 16'($urandom);
    rnd[d]  = $urandom;
  endtask

  // Checks one cycle of DUT d with already-driven inputs, advances the model,
  // then moves to the next falling edge. Capacity and latency are OUT_REG+1.
  task automatic cycle(input int d);
    logic exp_ready, exp_ov, f;
    #2;
    exp_ready = (q0.size() < d + 1) || out_ready[d];
    exp_ov    = (q0.size() > 0) && (cyc - fq[0] >= d + 1);
    f         = in_valid[d] && rnd_valid[d] && exp_ready;
    check("in_ready", 32'(in_ready[d]), 32'(exp_ready));
    check("out_valid", 32'(out_valid[d]), 32'(exp_ov));
    check("rnd_ack", 32'(rnd_ack[d]), 32'(f));
    if (exp_ov) begin
      check("out0", out0[d], q0[0]);
      check("out1", out1[d], q1[0]);
      check("unmasked", out0[d] ^ out1[d], q0[0] ^ q1[0]);
      if (out_ready[d]) begin
        void'(q0.pop_front()); void'(q1.pop_front()); void'(fq.pop_front());
      end
    end
    if (f) begin
      q0.push_back(model_share(d, 0));
      q1.push_back(model_share(d, 1));
      fq.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    in_valid[d] = 1'b0; rnd_valid[d] = 1'b0; out_ready[d] = 1'b1;
    repeat (4) cycle(d);
    check("drain_empty", 32'(q0.size()), 32'd0);
  endtask

  initial begin
    int first, last, nv;
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out0", out0[d], 32'd0);
      check("rst_out1", out1[d], 32'd0);
      check("rst_rnd_ack", 32'(rnd_ack[d]), 32'd0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Zero shares, rnd=0xA5 on lane 0: each share is just its mask, so lane 0
    // reads {rnd[3:0], rnd[7:4]} = 0x5A on both shares and unmasks to 0.
    in_valid[0] = 1'b1; rnd_valid[0] = 1'b1; rnd[0] = 32'h0000_00A5;
    cycle(0);
    in_valid[0] = 1'b0; rnd_valid[0] = 1'b0;
    #1;
    check("zero_out_valid", 32'(out_valid[0]), 32'd1);
    check("zero_out0", out0[0], 32'h0000_005A);
    check("zero_out1", out1[0], 32'h0000_005A);
    check("zero_xor", out0[0] ^ out1[0], 32'd0);
    drain(0);

    // Stall: result held for 5 cycles while new operands are offered.
    rand_ops(0); in_valid[0] = 1'b1; rnd_valid[0] = 1'b1;
    cycle(0);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_ops(0);
      cycle(0);
    end
    drain(0);

    // rnd_valid 0,0,1 with operands waiting: one fire, on the third cycle.
    rand_ops(0); in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_valid[0] = (i == 2);
      cycle(0);
    end
    drain(0);

    // Back-to-back: 8 fires give 8 consecutive valid cycles after the latency.
    for (int d = 0; d < 2; d++) begin
      first = -1; last = -1; nv = 0;
      for (int i = 0; i < 14; i++) begin
        rand_ops(d);
        in_valid[d] = (i < 8); rnd_valid[d] = 1'b1; out_ready[d] = 1'b1;
        #1;
        if (out_valid[d]) begin
          nv++;
          if (first < 0) first = i;
          last = i;
        end
        cycle(d);
      end
      check("b2b_count", 32'(nv), 32'd8);
      check("b2b_span", 32'(last - first + 1), 32'd8);
      check("b2b_latency", 32'(first), 32'(d + 1));
      drain(d);
    end

    // Random traffic on both configurations.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5000; i++) begin
        rand_ops(d);
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        rnd_valid[d] = ($urandom_range(0, 3) != 0);
        out_ready[d] = ($urandom_range(0, 3) != 0);
        cycle(d);
      end
      drain(d);
    end

    // Reset pulse of half a cycle with two results in flight (OUT_REG=1).
    for (int i = 0; i < 2; i++) begin
      rand_ops(1); in_valid[1] = 1'b1; rnd_valid[1] = 1'b1; out_ready[1] = 1'b1;
      cycle(1);
    end
    in_valid[1] = 1'b0; rnd_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid[1]), 32'd0);
    check("rst_mid_out0", out0[1], 32'd0);
    check("rst_mid_out1", out1[1], 32'd0);
    #4 rst_n = 1'b1;
    q0.delete(); q1.delete(); fq.delete();
    @(negedge clk);
    repeat (4) cycle(1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
